// File: rtl/imm_encoder_pkg.sv
// Shared format codes, opcodes and range helper for the immediate encoder
// and the core's immediate extractor.
package imm_encoder_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_U = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  // True when v[31:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
  function automatic logic upper_sext_ok(input logic [31:0] v, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> msb);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational immediate packer: scatters imm into the I/U/S/B/J bit
// positions of base and flags immediates the format cannot represent.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = base;
    err   = 1'b0;
    unique case (fmt)
      FMT_I: begin
        instr[31:20] = imm[11:0];
        err          = !upper_sext_ok(imm, 11);
      end
      FMT_U: begin
        instr[31:12] = imm[31:12];
        err          = (imm[11:0] != 12'd0);
      end
      FMT_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = !upper_sext_ok(imm, 11);
      end
      FMT_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        err          = !upper_sext_ok(imm, 12) || imm[0];
      end
      FMT_J: begin
        instr[31]    = imm[20];
        instr[19:12] = imm[19:12];
        instr[20]    = imm[11];
        instr[30:21] = imm[10:1];
        err          = !upper_sext_ok(imm, 20) || imm[0];
      end
      // Unknown format: template passes through untouched, beat is flagged.
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with running byte-address stamp
// and saturating count of errored beats delivered downstream.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [31:0]         in_base,
  input  logic [31:0]         in_imm,
  input  logic                addr_load,
  input  logic [ADDR_W-1:0]   addr_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic                run;
  logic                s1_valid;
  logic [2:0]          s1_fmt;
  logic [31:0]         s1_base;
  logic [31:0]         s1_imm;
  logic                s2_valid;
  logic [31:0]         s2_instr;
  logic                s2_err;
  logic [ADDR_W-1:0]   addr_q;
  logic [ERRCNT_W-1:0] errcnt_q;
  logic [31:0]         pack_instr;
  logic                pack_err;
  logic                s2_ready;
  logic                out_hs;

  assign s2_ready = !s2_valid || out_ready;
  // run keeps in_ready low throughout reset and releases it on the first clock after.
  assign in_ready = run && (!s1_valid || s2_ready);
  assign out_hs   = s2_valid && out_ready;

  imm_pack u_pack (
    .fmt   (s1_fmt),
    .base  (s1_base),
    .imm   (s1_imm),
    .instr (pack_instr),
    .err   (pack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= '0;
      s1_base  <= '0;
      s1_imm   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt  <= in_fmt;
        s1_base <= in_base;
        s1_imm  <= in_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= pack_instr;
        s2_err   <= pack_err;
      end
    end
  end

  // A load wins over the increment; the beat leaving this cycle already saw the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         addr_q <= '0;
    else if (addr_load) addr_q <= addr_value;
    else if (out_hs)    addr_q <= addr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      errcnt_q <= '0;
    else if (out_hs && s2_err && (errcnt_q != '1))
      errcnt_q <= errcnt_q + ERRCNT_W'(1);
  end

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;
  assign out_addr  = addr_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: scoreboard against an arithmetic encoding
// model, round-trip through the core's extractor, plus literal expectations.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [31:0] in_base = '0;
  logic [31:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] err_count;

  imm_encoder #(.ADDR_W(32), .ERRCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
    .addr_load(addr_load), .addr_value(addr_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // {err, instr} from the encoding rules, expressed with masks, shifts and signed ranges.
  function automatic logic [32:0] enc_model(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
    logic signed [31:0] s;
    logic [31:0] w;
    logic e;
    s = $signed(i);
    case (f)
      3'd0: begin
        w = (b & 32'h000F_FFFF) | (i << 20);
        e = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w = (b & 32'h0000_0FFF) | (i & 32'hFFFF_F000);
        e = (i & 32'h0000_0FFF) != 0;
      end
      3'd2: begin
        w = (b & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (b & 32'h01FF_F07F) | (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
          | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
        e = (s < -4096) || (s > 4095) || (i % 2 != 0);
      end
      3'd4: begin
        w = (b & 32'h0000_0FFF) | (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
          | (((i >> 11) & 32'h1) << 20) | (i & 32'h000F_F000);
        e = (s < -1048576) || (s > 1048575) || (i % 2 != 0);
      end
      default: begin
        w = b;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // The core's immediate extractor.
  function automatic logic [31:0] extract(input logic [2:0] f, input logic [31:0] x);
    case (f)
      FMT_I:   return {{20{x[31]}}, x[31:20]};
      FMT_U:   return {x[31:12], 12'b0};
      FMT_S:   return {{20{x[31]}}, x[31:25], x[11:7]};
      FMT_B:   return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      FMT_J:   return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] base;
    logic [31:0] imm;
  } beat_t;

  beat_t       q[$];
  logic [31:0] log_instr[$];
  logic [31:0] log_addr[$];
  logic        log_err[$];
  logic [31:0] m_addr = '0;
  logic [15:0] m_errs = '0;
  logic        stalled = 1'b0;
  logic [31:0] prev_instr, prev_addr;
  logic        prev_err;

  always @(negedge clk) begin
    logic [32:0] m;
    beat_t b;
    if (!rst_n) begin
      q.delete();
      m_addr  = '0;
      m_errs  = '0;
      stalled = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
    end else begin
      chk("err_count", 64'(err_count), 64'(m_errs));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          b = q[0];
          m = enc_model(b.fmt, b.base, b.imm);
          chk("out_instr", 64'(out_instr), 64'(m[31:0]));
          chk("out_err", 64'(out_err), 64'(m[32]));
          chk("out_addr", 64'(out_addr), 64'(m_addr));
          if (!m[32]) chk("round_trip", 64'(extract(b.fmt, out_instr)), 64'(b.imm));
        end
        if (stalled) begin
          chk("stall_instr", 64'(out_instr), 64'(prev_instr));
          chk("stall_addr", 64'(out_addr), 64'(prev_addr));
          chk("stall_err", 64'(out_err), 64'(prev_err));
        end
      end else if (stalled) begin
        chk("stall_valid_held", 64'(out_valid), 64'd1);
      end
      stalled    = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_addr  = out_addr;
      prev_err   = out_err;
      if (out_valid && out_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        log_instr.push_back(out_instr);
        log_addr.push_back(out_addr);
        log_err.push_back(out_err);
        if (out_err && m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
      end
      if (addr_load) m_addr = addr_value;
      else if (out_valid && out_ready) m_addr = m_addr + 32'd4;
      if (in_valid && in_ready) begin
        b.fmt  = in_fmt;
        b.base = in_base;
        b.imm  = in_imm;
        q.push_back(b);
      end
    end
  end

  // Called and returning at posedge+1; the beat is accepted on the edge just passed.
  task automatic send(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
    int n;
    in_valid = 1'b1;
    in_fmt   = f;
    in_base  = b;
    in_imm   = i;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [32:0] pin;

    pin = enc_model(FMT_I, 32'h13, 32'hFFFF_F800);
    chk("model_I", 64'(pin), {31'd0, 1'b0, 32'h8000_0013});
    pin = enc_model(FMT_B, 32'h63, 32'h0000_0FFE);
    chk("model_B", 64'(pin), {31'd0, 1'b0, 32'h7E00_0FE3});
    pin = enc_model(FMT_U, 32'h37, 32'h1234_5000);
    chk("model_U", 64'(pin), {31'd0, 1'b0, 32'h1234_5037});
    pin = enc_model(FMT_J, 32'h6F, 32'h1);
    chk("model_J_odd_err", 64'(pin[32]), 64'd1);

    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Format mix, no backpressure.
    b0 = log_instr.size();
    send(FMT_I, {25'd0, OPC_OP_IMM}, 32'hFFFF_F800);
    send(FMT_S, 32'h0000_2000 | {25'd0, OPC_STORE}, 32'd2047);
    send(FMT_B, {25'd0, OPC_BRANCH}, 32'h0000_0FFE);
    send(FMT_B, {25'd0, OPC_BRANCH}, 32'h0000_1000);
    send(FMT_J, {25'd0, OPC_JAL}, 32'h0000_0001);
    send(FMT_U, {25'd0, OPC_LUI}, 32'h1234_5000);
    send(3'd6, 32'hDEAD_BEEF, 32'h0);
    send(FMT_J, 32'h80 | {25'd0, OPC_JAL}, 32'hFFFF_FFFE);
    drain();
    chk("lit_I_instr", 64'(log_instr[b0]), 64'h8000_0013);
    chk("lit_I_addr", 64'(log_addr[b0]), 64'd0);
    chk("lit_S_addr", 64'(log_addr[b0+1]), 64'd4);
    chk("lit_S_instr", 64'(log_instr[b0+1]), 64'h7E00_2FA3);
    chk("lit_B_instr", 64'(log_instr[b0+2]), 64'h7E00_0FE3);
    chk("lit_B_err0", 64'(log_err[b0+2]), 64'd0);
    chk("lit_B_range_err", 64'(log_err[b0+3]), 64'd1);
    chk("lit_B_range_instr", 64'(log_instr[b0+3]), 64'h8000_0063);
    chk("lit_J_odd_err", 64'(log_err[b0+4]), 64'd1);
    chk("lit_U_instr", 64'(log_instr[b0+5]), 64'h1234_5037);
    chk("lit_bad_fmt_instr", 64'(log_instr[b0+6]), 64'hDEAD_BEEF);
    chk("lit_bad_fmt_err", 64'(log_err[b0+6]), 64'd1);
    chk("lit_J_neg_instr", 64'(log_instr[b0+7]), 64'hFFFF_F0EF);
    chk("lit_err_count", 64'(err_count), 64'd3);

    // Six back-to-back beats with a three-cycle downstream stall.
    addr_value = 32'h0;
    addr_load  = 1'b1;
    @(posedge clk);
    #1 addr_load = 1'b0;
    b0 = log_instr.size();
    fork
      begin
        for (int k = 0; k < 6; k++) send(FMT_I, {25'd0, OPC_OP_IMM}, 32'(k));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    for (int k = 0; k < 6; k++) begin
      chk("bp_order", 64'(log_instr[b0+k]), 64'((32'(k) << 20) | 32'h13));
      chk("bp_addr", 64'(log_addr[b0+k]), 64'(32'(4 * k)));
    end

    // Address load coinciding with a transfer, then wrap.
    b0 = log_instr.size();
    out_ready = 1'b0;
    send(FMT_I, {25'd0, OPC_OP_IMM}, 32'd100);
    send(FMT_I, {25'd0, OPC_OP_IMM}, 32'd101);
    repeat (2) @(posedge clk);
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    addr_value = 32'hFFFF_FFFC;
    addr_load  = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1 addr_load = 1'b0;
    send(FMT_I, {25'd0, OPC_OP_IMM}, 32'd102);
    drain();
    chk("load_old_addr", 64'(log_addr[b0]), 64'd24);
    chk("load_new_addr", 64'(log_addr[b0+1]), 64'hFFFF_FFFC);
    chk("load_wrap_addr", 64'(log_addr[b0+2]), 64'd0);
    chk("load_wrap_instr", 64'(log_instr[b0+2]), 64'h0660_0013);

    // Reset with both stages full, then first beat latency.
    out_ready = 1'b0;
    send(FMT_B, {25'd0, OPC_BRANCH}, 32'h0000_2000);
    send(FMT_I, {25'd0, OPC_OP_IMM}, 32'd7);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_err_count", 64'(err_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_err_count", 64'(err_count), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("post_rst_addr", 64'(out_addr), 64'd0);
    send(FMT_I, {25'd0, OPC_OP_IMM}, 32'd1);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_instr", 64'(out_instr), 64'h0010_0013);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
